// File: rtl/ro_enable_decoder_pkg.sv
// ro_enable_decoder_pkg: shared FSM encoding, defaults and log2 helper
package ro_enable_decoder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_t;
  localparam int GAP_CYCLES_DEF = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ro_enable_decoder_onehot_decode.sv
// onehot_decode: combinational index to one-hot decoder with range check
module onehot_decode #(
  parameter int DEPTH = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0]    idx,
  output logic [DEPTH-1:0] onehot,
  output logic             legal
);
  assign legal = 32'(idx) < DEPTH;
  assign onehot = legal ? DEPTH'(1) << idx : '0;
endmodule

// File: rtl/ro_enable_decoder.sv
// ro_enable_decoder: registered one-hot RO enable with timed window and guard gap
module ro_enable_decoder
  import ro_enable_decoder_pkg::*;
#(
  parameter int DECODER_DEPTH = 4,
  parameter int log2N = 2,
  parameter int WIN_W = 16,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [log2N-1:0]         IDX_IN,
  input  logic [WIN_W-1:0]         WINDOW,
  input  logic                     IDX_VALID,
  output logic                     IDX_READY,
  input  logic                     ABORT,
  output logic [DECODER_DEPTH-1:0] EN_OUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);
  localparam int GW = clog2(GAP_CYCLES + 1);
  state_t st, st_n;
  logic [WIN_W-1:0] win, win_n;
  logic [GW-1:0] gap, gap_n;
  logic ab, ab_n, legal, done_n, err_n;
  logic [DECODER_DEPTH-1:0] onehot, en_n;
  onehot_decode #(.DEPTH(DECODER_DEPTH), .IW(log2N)) u_dec (
    .idx(IDX_IN),
    .onehot(onehot),
    .legal(legal)
  );
  // state, counters and every output are flops so EN_OUT never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      win <= '0;
      gap <= '0;
      ab <= 1'b0;
      EN_OUT <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
      IDX_READY <= 1'b1;
    end else begin
      st <= st_n;
      win <= win_n;
      gap <= gap_n;
      ab <= ab_n;
      EN_OUT <= en_n;
      BUSY <= st_n != ST_IDLE;
      DONE <= done_n;
      ERR <= err_n;
      IDX_READY <= st_n == ST_IDLE;
    end
  end
  // next state: abort latches into ab so DONE is suppressed at the end of the gap
  always_comb begin
    st_n = st;
    win_n = win;
    gap_n = gap;
    ab_n = ab;
    en_n = EN_OUT;
    done_n = 1'b0;
    err_n = 1'b0;
    case (st)
      ST_IDLE: if (IDX_VALID) begin
        err_n = !legal;
        if (legal) begin
          ab_n = 1'b0;
          win_n = WINDOW;
          gap_n = GW'(GAP_CYCLES);
          en_n = WINDOW == '0 ? '0 : onehot;
          st_n = WINDOW == '0 ? ST_GAP : ST_ACTIVE;
        end
      end
      ST_ACTIVE: if (ABORT || win == WIN_W'(1)) begin
        st_n = ST_GAP;
        en_n = '0;
        ab_n = ABORT;
      end else begin
        win_n = win - WIN_W'(1);
      end
      ST_GAP: begin
        ab_n = ab | ABORT;
        gap_n = gap - GW'(1);
        if (gap == GW'(1)) begin
          st_n = ST_IDLE;
          done_n = !(ab | ABORT);
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ro_enable_decoder.sv
// tb_ro_enable_decoder: random and directed checks against a timeline model
module tb_ro_enable_decoder;
  logic clk = 0, rst_n = 0;
  logic [1:0] IDX_IN = 0;
  logic [15:0] WINDOW = 0;
  logic IDX_VALID = 0, ABORT = 0;
  logic [3:0] en4;
  logic [2:0] en3;
  logic rdy4, busy4, done4, err4, rdy3, busy3, done3, err3;
  int total = 0, passed = 0;
  localparam int G = 2;
  always #5 clk = ~clk;
  ro_enable_decoder #(.DECODER_DEPTH(4), .log2N(2), .WIN_W(16), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .IDX_IN(IDX_IN), .WINDOW(WINDOW), .IDX_VALID(IDX_VALID),
    .IDX_READY(rdy4), .ABORT(ABORT), .EN_OUT(en4), .BUSY(busy4), .DONE(done4), .ERR(err4));
  ro_enable_decoder #(.DECODER_DEPTH(3), .log2N(2), .WIN_W(16), .GAP_CYCLES(G)) dut3 (
    .clk(clk), .rst_n(rst_n), .IDX_IN(IDX_IN), .WINDOW(WINDOW), .IDX_VALID(IDX_VALID),
    .IDX_READY(rdy3), .ABORT(ABORT), .EN_OUT(en3), .BUSY(busy3), .DONE(done3), .ERR(err3));
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
  endtask
  // timeline model: a request owns the block until act_end + G; enable is high while edge < act_end
  int cyc_n = 0;
  int depth[2] = '{4, 3};
  bit inreq[2], ab[2];
  int act_end[2], idx[2], e_en[2], e_done[2], e_err[2];
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      cyc_n = 0;
      for (int i = 0; i < 2; i++) begin
        inreq[i] = 0; ab[i] = 0; e_en[i] = 0; e_done[i] = 0; e_err[i] = 0;
      end
    end else begin
      cyc_n++;
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 0;
        e_err[i] = 0;
        if (inreq[i]) begin
          if (ABORT) begin
            ab[i] = 1;
            if (cyc_n < act_end[i]) act_end[i] = cyc_n;
          end
          if (cyc_n == act_end[i] + G) begin
            inreq[i] = 0;
            e_done[i] = !ab[i];
          end
        end else if (IDX_VALID) begin
          if (int'(IDX_IN) >= depth[i]) e_err[i] = 1;
          else begin
            inreq[i] = 1; ab[i] = 0; idx[i] = int'(IDX_IN);
            act_end[i] = cyc_n + int'(WINDOW);
          end
        end
        e_en[i] = (inreq[i] && cyc_n < act_end[i]) ? (1 << idx[i]) : 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("en4", int'(en4), e_en[0]);
      chk("busy4", int'(busy4), int'(inreq[0]));
      chk("rdy4", int'(rdy4), int'(!inreq[0]));
      chk("done4", int'(done4), e_done[0]);
      chk("err4", int'(err4), e_err[0]);
      chk("onehot4", int'($countones(en4) <= 1), 1);
      chk("en3", int'(en3), e_en[1]);
      chk("busy3", int'(busy3), int'(inreq[1]));
      chk("rdy3", int'(rdy3), int'(!inreq[1]));
      chk("done3", int'(done3), e_done[1]);
      chk("err3", int'(err3), e_err[1]);
    end
  end
  task automatic drive(input bit v, input int i, input int w);
    IDX_VALID = v;
    IDX_IN = 2'(i);
    WINDOW = 16'(w);
  endtask
  task automatic idle_wait();
    drive(0, 0, 0);
    ABORT = 0;
    repeat (12) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_en", int'(en4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_done", int'(done4), 0);
    chk("rst_err", int'(err4), 0);
    chk("rst_rdy", int'(rdy4), 1);
    rst_n = 1;
    idle_wait();
    drive(1, 2, 5);
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      if (m == 0) IDX_VALID = 0;
      chk("t1_en", int'(en4), m < 5 ? 4 : 0);
      chk("t1_done", int'(done4), int'(m == 7));
      if (m == 7) chk("t1_rdy", int'(rdy4), 1);
    end
    idle_wait();
    drive(1, 3, 0);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      if (m == 0) IDX_VALID = 0;
      chk("t2_err", int'(err3), int'(m == 0));
      chk("t2_en", int'(en3), 0);
      chk("t2_rdy", int'(rdy3), 1);
      chk("t2_done", int'(done3), 0);
    end
    idle_wait();
    drive(1, 1, 0);
    for (int m = 0; m < 4; m++) begin
      @(negedge clk);
      if (m == 0) IDX_VALID = 0;
      chk("t3_en", int'(en4), 0);
      chk("t3_done", int'(done4), int'(m == 2));
    end
    idle_wait();
    drive(1, 0, 10);
    for (int m = 0; m < 8; m++) begin
      @(negedge clk);
      if (m == 0) IDX_VALID = 0;
      chk("t4_en", int'(en4), m < 4 ? 1 : 0);
      chk("t4_busy", int'(busy4), int'(m < 6));
      chk("t4_done", int'(done4), 0);
      ABORT = (m == 3);
    end
    idle_wait();
    drive(1, 3, 3);
    for (int m = 0; m < 9; m++) begin
      @(negedge clk);
      if (m == 0) begin IDX_IN = 0; WINDOW = 2; end
      if (m == 6) IDX_VALID = 0;
      chk("t5_en", int'(en4), m < 3 ? 8 : (m == 6 || m == 7) ? 1 : 0);
      chk("t5_done", int'(done4), int'(m == 5));
    end
    idle_wait();
    drive(1, 1, 8);
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      if (m == 0) IDX_VALID = 0;
      chk("t6_en_pre", int'(en4), 2);
    end
    #3 rst_n = 0;
    #1 chk("t6_en_async", int'(en4), 0);
    chk("t6_done_async", int'(done4), 0);
    chk("t6_busy_async", int'(busy4), 0);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("t6_rdy", int'(rdy4), 1);
    chk("t6_done", int'(done4), 0);
    chk("t6_busy", int'(busy4), 0);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0 ? int'($urandom_range(20, 40)) : int'($urandom_range(0, 5)));
      ABORT = $urandom_range(0, 9) == 0;
    end
    idle_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
